// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and constants for the generic pipeline stage register and the
// packed stage payloads that size it.
package pipe_stage_reg_pkg;

  typedef logic [1:0] pipe_occ_t;

  localparam int PIPE_CNT_W_DEFAULT = 16;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR_HEX = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_payload_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        reg_write_en;
  } idex_payload_t;

  localparam ifid_payload_t IFID_BUBBLE = '{pc: 32'h0, instr: NOP_INSTR_HEX};
  localparam idex_payload_t IDEX_BUBBLE = '{pc: 32'h0, instr: NOP_INSTR_HEX,
                                            rs1_val: 32'h0, rs2_val: 32'h0,
                                            reg_write_en: 1'b0};

  function automatic pipe_occ_t occ_count(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with optional skid entry,
// stall freeze, flush-with-bubble and saturating performance counters.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                 DATA_W     = 32,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0,
  parameter bit                 SKID_EN    = 1'b1,
  parameter int                 CNT_W      = PIPE_CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              stall,
  input  logic              flush,
  output pipe_occ_t         occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              h_valid;
  logic              s_valid;
  logic [DATA_W-1:0] h_data;
  logic              base_ready;
  logic              hold;
  logic              accept;
  logic              pop;

  // Flush outranks stall; the head is also hidden during a flush because it is
  // being discarded, not handed downstream.
  assign hold      = stall & ~flush;
  assign out_valid = h_valid & ~stall & ~flush;
  assign in_ready  = base_ready & ~hold;
  assign accept    = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? h_data : BUBBLE_VAL;
  assign occupancy = occ_count(h_valid, s_valid);

  generate
    if (SKID_EN) begin : g_skid
      logic [DATA_W-1:0] s_data;

      assign base_ready = ~s_valid;

      always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
          h_valid <= 1'b0;
          h_data  <= BUBBLE_VAL;
          s_valid <= 1'b0;
          s_data  <= BUBBLE_VAL;
        end else if (pop) begin
          if (s_valid) begin
            h_data  <= s_data;
            s_valid <= 1'b0;
            s_data  <= BUBBLE_VAL;
          end else if (accept) begin
            h_data <= in_data;
          end else begin
            h_valid <= 1'b0;
            h_data  <= BUBBLE_VAL;
          end
        end else if (accept) begin
          if (!h_valid) begin
            h_valid <= 1'b1;
            h_data  <= in_data;
          end else begin
            s_valid <= 1'b1;
            s_data  <= in_data;
          end
        end
      end
    end else begin : g_single
      assign base_ready = ~h_valid | out_ready;
      assign s_valid    = 1'b0;

      always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
          h_valid <= 1'b0;
          h_data  <= BUBBLE_VAL;
        end else if (accept) begin
          h_valid <= 1'b1;
          h_data  <= in_data;
        end else if (pop) begin
          h_valid <= 1'b0;
          h_data  <= BUBBLE_VAL;
        end
      end
    end
  endgenerate

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush & (h_valid | s_valid)),
    .cnt   (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~out_valid & out_ready),
    .cnt   (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: a skid-buffered stage and a single-entry stage with narrow
// counters share one stimulus stream and are checked against a queue model.
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  localparam logic [31:0] BUB0 = NOP_INSTR_HEX;
  localparam logic [31:0] BUB1 = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;

  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [31:0] out_data0, out_data1;
  pipe_occ_t   occ0, occ1;
  logic [15:0] stall_cnt0, flush_cnt0, bubble_cnt0;
  logic [3:0]  stall_cnt1, flush_cnt1, bubble_cnt1;

  pipe_stage_reg #(.DATA_W(32), .BUBBLE_VAL(BUB0), .SKID_EN(1'b1), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .stall(stall), .flush(flush), .occupancy(occ0),
    .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0), .bubble_cnt(bubble_cnt0)
  );

  pipe_stage_reg #(.DATA_W(32), .BUBBLE_VAL(BUB1), .SKID_EN(1'b0), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .stall(stall), .flush(flush), .occupancy(occ1),
    .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1), .bubble_cnt(bubble_cnt1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: queue of held payloads plus the beat accepted this cycle at its back.
  logic [31:0] exp0[$];
  logic [31:0] exp1[$];
  bit acc0 = 1'b0;
  bit acc1 = 1'b0;
  int sc0 = 0, fc0 = 0, bc0 = 0;
  int sc1 = 0, fc1 = 0, bc1 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  function automatic bit model_ir(input bit skid, input int held, input bit st,
                                  input bit fl, input bit ordy);
    if (st && !fl) return 1'b0;
    if (skid) return held < 2;
    return (held == 0) || ordy;
  endfunction

  function automatic int sat_inc(input int v, input int w);
    return (v < (1 << w) - 1) ? v + 1 : v;
  endfunction

  task automatic mon(input string tag, input bit skid, input int w, input logic [31:0] bub,
                     ref logic [31:0] q[$], input bit acc, ref int sc, ref int fc, ref int bc,
                     input logic ir, input logic ov, input logic [31:0] od, input pipe_occ_t occ,
                     input logic [31:0] scnt, input logic [31:0] fcnt, input logic [31:0] bcnt);
    int held;
    bit e_ov;
    held = q.size() - int'(acc);
    e_ov = (held > 0) && !stall && !flush;
    chk({tag, ".in_ready"}, {31'b0, ir}, {31'b0, model_ir(skid, held, stall, flush, out_ready)});
    chk({tag, ".out_valid"}, {31'b0, ov}, {31'b0, e_ov});
    chk({tag, ".occupancy"}, {30'b0, occ}, 32'(held));
    chk({tag, ".stall_cnt"}, scnt, 32'(sc));
    chk({tag, ".flush_cnt"}, fcnt, 32'(fc));
    chk({tag, ".bubble_cnt"}, bcnt, 32'(bc));
    if (e_ov) chk({tag, ".data"}, od, q[0]);
    else      chk({tag, ".bubble_data"}, od, bub);
    if (!rst_n) begin
      q.delete();
      sc = 0; fc = 0; bc = 0;
    end else begin
      if (stall) sc = sat_inc(sc, w);
      if (flush && held > 0) fc = sat_inc(fc, w);
      if (!e_ov && out_ready) bc = sat_inc(bc, w);
      if (flush) q.delete();
      else if (e_ov && out_ready) void'(q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    mon("skid", 1'b1, 16, BUB0, exp0, acc0, sc0, fc0, bc0, in_ready0, out_valid0, out_data0,
        occ0, 32'(stall_cnt0), 32'(flush_cnt0), 32'(bubble_cnt0));
    mon("single", 1'b0, 4, BUB1, exp1, acc1, sc1, fc1, bc1, in_ready1, out_valid1, out_data1,
        occ1, 32'(stall_cnt1), 32'(flush_cnt1), 32'(bubble_cnt1));
  end

  task automatic cyc(input bit iv, input logic [31:0] d, input bit st, input bit fl,
                     input bit ordy, input bit rs);
    @(posedge clk);
    #1;
    rst_n     = rs;
    in_valid  = iv;
    in_data   = d;
    stall     = st;
    flush     = fl;
    out_ready = ordy;
    acc0 = rs && iv && !fl && model_ir(1'b1, exp0.size(), st, fl, ordy);
    acc1 = rs && iv && !fl && model_ir(1'b0, exp1.size(), st, fl, ordy);
    if (acc0) exp0.push_back(d);
    if (acc1) exp1.push_back(d);
  endtask

  initial begin
    logic [31:0] d;
    repeat (3) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'hDEAD0001, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);

    d = 32'd1;
    for (int k = 0; k < 14; k++) begin
      cyc(d <= 32'd4, d, 1'b0, 1'b0, k >= 6, 1'b1);
      if (acc0) d = d + 1;
    end

    cyc(1'b1, 32'h0000_00AA, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h0000_00BB, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h0000_00CC, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);

    cyc(1'b1, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (4) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (3) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);

    for (int k = 0; k < 10; k++) cyc(1'b1, 32'(k), 1'b0, 1'b0, 1'b1, 1'b1);

    for (int k = 0; k < 600; k++)
      cyc($urandom_range(9, 0) < 7, $urandom, $urandom_range(9, 0) == 0,
          $urandom_range(19, 0) == 0, $urandom_range(9, 0) < 6, 1'b1);

    repeat (20) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (2) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register with a valid/ready handshake. It replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block.
- Payload width, bubble encoding and skid buffering are set by parameters.
- Adds backpressure, a stall freeze, flush with bubble injection, an occupancy output and saturating performance counters. The fixed-function stage registers have none of these.
- Sits between any two CPU pipeline stages. The hazard unit drives stall/flush.

Parameters:
- DATA_W, 32, payload width in bits (packed stage struct), min 1.
- BUBBLE_VAL, '0, payload presented on out_data when out_valid=0 (e.g. a packed NOP, instr field = NOP_INSTR_HEX).
- SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  stage holds a valid payload for downstream.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  head payload, or BUBBLE_VAL when out_valid=0.
- stall  in  1  freeze: no accept, no emit, contents held.
- flush  in  1  discard all held payloads; the incoming beat is also dropped.
- occupancy  out  2  entries held (0..2; 0..1 when SKID_EN=0).
- stall_cnt  out  CNT_W  cycles with stall=1.
- flush_cnt  out  CNT_W  cycles with flush=1 that discarded ≥1 valid entry.
- bubble_cnt  out  CNT_W  cycles with out_valid=0 and out_ready=1.

Behaviour:
- Reset (rst_n=0 at posedge): both entries invalid, entry data = BUBBLE_VAL, all counters 0.
  - Resulting outputs: out_valid=0, out_data=BUBBLE_VAL, occupancy=0.
  - in_ready=1 the cycle after reset releases.
  - Reset overrides stall and flush.
- Transfer rules:
  - Accept when in_valid & in_ready.
  - Pop when out_valid & out_ready.
  - Latency is 1 cycle: a beat accepted at edge N is on out_data after edge N with out_valid=1.
- Priority: reset > flush > stall > normal.
- Flush:
  - Next edge: both entries invalid, data = BUBBLE_VAL, occupancy=0.
  - in_data presented in the flush cycle is not captured, even if in_valid=1.
  - in_ready during flush follows normal rules, but no accept occurs.
- Stall (flush=0):
  - in_ready=0 and out_valid=0 combinationally; out_data=BUBBLE_VAL.
  - Entries and occupancy are held unchanged.
  - A released stall re-presents the held head payload on the next cycle.
- SKID_EN=1:
  - Head register H and skid register S.
  - in_ready = !S.valid, registered and independent of out_ready.
  - Accept with H empty or popping → write H.
  - Accept with H full and not popping → write S.
  - Pop with S valid → S moves to H; this cycle's accept (only possible if S was empty) is not allowed.
  - Simultaneous accept and pop with H valid and S empty → H takes in_data; occupancy unchanged.
  - Full (occupancy=2) → in_ready=0 next cycle until a pop.
- SKID_EN=0:
  - Only H exists; in_ready = !H.valid | out_ready (combinational).
  - Simultaneous accept and pop replaces H.
- Ordering: payloads emerge in acceptance order; none is duplicated or lost except on flush.
- Counters:
  - Saturate at all-ones; no wrap.
  - Stall and flush in the same cycle: flush_cnt increments if ≥1 valid entry was discarded; stall_cnt always increments.
- The stage does not inspect in_data. NOP detection and regWriteEnable policy belong upstream in the decoder.

Decomposition:
- common_def additions:
  - pipe_occ_t (logic [1:0]).
  - PIPE_CNT_W_DEFAULT = 16.
  - Packed stage structs (e.g. idex_payload_t) whose widths feed DATA_W via $bits.
  - Bubble constants per struct, built from NOP_INSTR_HEX.
- Sub-module sat_counter (params W; ports clk, rst_n, inc, cnt): sync active-low clear, saturating increment. Instantiated three times.

Test Plan:
- Reset and first beat:
  - Stimulus: hold rst_n=0 for 3 cycles, release; drive in_valid=1, in_data=32'hDEAD0001 with out_ready=1.
  - Response: out_valid=0 and out_data=BUBBLE_VAL during reset; out_valid=1, out_data=32'hDEAD0001 one cycle after accept.
- Backpressure with skid (SKID_EN=1):
  - Stimulus: stream 1,2,3,4 with out_ready=0 from cycle 1.
  - Response: 1 in H, 2 in S, occupancy=2, in_ready=0.
  - Then raise out_ready: outputs 1,2,3,4 in order, no loss.
- Flush mid-stream:
  - Stimulus: with occupancy=2 (A,B), assert flush with in_valid=1, in_data=C.
  - Response: next cycle occupancy=0, out_valid=0, out_data=BUBBLE_VAL, C never emitted, flush_cnt=1.
- Stall hold:
  - Stimulus: H=5, stall=1 for 4 cycles with out_ready=1.
  - Response: out_valid=0 for those cycles, in_ready=0, stall_cnt=4.
  - On release: 5 is emitted exactly once.
- SKID_EN=0 full-throughput:
  - Stimulus: in_valid=1, out_ready=1 continuously, data 0..9.
  - Response: in_ready=1 every cycle; out_data 0..9 on consecutive cycles, each 1 cycle after input.
- Counter saturation:
  - Stimulus: CNT_W=4, hold stall=1 for 20 cycles.
  - Response: stall_cnt stops at 4'hF; a mid-run reset clears it to 0.
